// File: rtl/bp_fe_ras.sv
// bp_fe_ras -- speculative return-address stack for the fetch front end.
//
// A call pushes pc+4. A return pops the top entry and predicts it in the
// same cycle. A call that is also a return replaces the top entry in place.
// A mispredict (restore_i) rolls back the stack state and inserts one cycle
// during which no scans are accepted.
//
// Optional feature macro: BP_FE_RAS_CKPT_EN
//   defined   : ckpt_save_i snapshots tos/count; restore_i reloads that snapshot
//   undefined : no snapshot registers; ckpt_save_i is ignored; restore_i empties the stack
//
// Ports
//   clk_i        in   sole clock, rising edge
//   reset_n_i    in   synchronous active-low reset
//   scan_v_i     in   scan result valid
//   call_i       in   scanned instruction is a call
//   ret_i        in   scanned instruction is a return
//   pc_i         in   PC of the scanned instruction
//   ready_o      out  scans accepted this cycle
//   pred_v_o     out  return prediction valid (combinational)
//   pred_addr_o  out  predicted return target (0 when not valid)
//   ckpt_save_i  in   snapshot tos/count after this cycle's operation
//   restore_i    in   mispredict: roll back speculative state
//   count_o      out  number of valid entries
module bp_fe_ras #(
    parameter int vaddr_width_p = 39,
    parameter int ras_els_p     = 8
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic                               scan_v_i,
    input  logic                               call_i,
    input  logic                               ret_i,
    input  logic [vaddr_width_p-1:0]           pc_i,
    output logic                               ready_o,
    output logic                               pred_v_o,
    output logic [vaddr_width_p-1:0]          pred_addr_o,
    input  logic                               ckpt_save_i,
    input  logic                               restore_i,
    output logic [$clog2(ras_els_p+1)-1:0]     count_o
);

    localparam int PTR_W = $clog2(ras_els_p);
    localparam int CNT_W = $clog2(ras_els_p + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ras_els_p);

    typedef enum logic {
        e_run,
        e_restore
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic [PTR_W-1:0]          r_tos;
    logic [CNT_W-1:0]          r_count;
    logic [vaddr_width_p-1:0]  r_mem [ras_els_p];

    logic                      w_accept;
    logic                      w_has;
    logic                      w_push;
    logic                      w_swap;
    logic                      w_pop;
    logic                      w_we;
    logic [PTR_W-1:0]          w_waddr;
    logic [vaddr_width_p-1:0]  w_ret_addr;
    logic [PTR_W-1:0]          w_tos_next;
    logic [CNT_W-1:0]          w_count_next;
    logic [PTR_W-1:0]          w_rest_tos;
    logic [CNT_W-1:0]          w_rest_count;

`ifdef BP_FE_RAS_CKPT_EN
    logic [PTR_W-1:0]          r_ckpt_tos;
    logic [CNT_W-1:0]          r_ckpt_count;

    assign w_rest_tos   = r_ckpt_tos;
    assign w_rest_count = r_ckpt_count;

    // Snapshot reflects this cycle's accepted operation; a same-cycle
    // restore takes precedence and leaves the snapshot untouched.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_ckpt_tos   <= '0;
            r_ckpt_count <= '0;
        end else if (ckpt_save_i && !restore_i) begin
            r_ckpt_tos   <= w_tos_next;
            r_ckpt_count <= w_count_next;
        end
    end
`else
    logic w_unused_ckpt;
    assign w_unused_ckpt = ckpt_save_i;
    assign w_rest_tos    = '0;
    assign w_rest_count  = '0;
`endif

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state <= e_run;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: one bubble cycle after every restore request
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            e_run:     if (restore_i) w_state_next = e_restore;
            e_restore: w_state_next = restore_i ? e_restore : e_run;
            default:   w_state_next = e_run;
        endcase
    end

    // Operation decode and next pointer/count
    always_comb begin
        w_accept     = reset_n_i & scan_v_i & (r_state == e_run) & !restore_i;
        w_has        = (r_count != '0);
        // call+ret on an empty stack degenerates to a plain push
        w_push       = w_accept & call_i & (!ret_i | !w_has);
        w_swap       = w_accept & call_i & ret_i & w_has;
        w_pop        = w_accept & ret_i & !call_i & w_has;
        w_ret_addr   = pc_i + vaddr_width_p'(4);
        w_we         = w_push | w_swap;
        w_waddr      = w_push ? (r_tos + PTR_W'(1)) : r_tos;
        w_tos_next   = r_tos;
        w_count_next = r_count;
        if (w_push) begin
            w_tos_next   = r_tos + PTR_W'(1);
            // when full the pointer wraps over the oldest entry
            w_count_next = (r_count == FULL_CNT) ? r_count : r_count + CNT_W'(1);
        end else if (w_pop) begin
            w_tos_next   = r_tos - PTR_W'(1);
            w_count_next = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_tos   <= '0;
            r_count <= '0;
        end else if (restore_i) begin
            r_tos   <= w_rest_tos;
            r_count <= w_rest_count;
        end else begin
            r_tos   <= w_tos_next;
            r_count <= w_count_next;
        end
    end

    // Entry storage is not reset; only tos/count qualify its contents.
    always_ff @(posedge clk_i) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_ret_addr;
        end
    end

    // Outputs are forced to their reset values while reset is asserted.
    assign pred_v_o    = w_accept & ret_i & w_has;
    assign pred_addr_o = pred_v_o ? r_mem[r_tos] : '0;
    assign ready_o     = !reset_n_i | (r_state == e_run);
    assign count_o     = reset_n_i ? r_count : '0;

endmodule
